fifo_write_arbiter: RTL and testbench

FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

---
 rtl/fifo_write_arbiter.sv | 155 +++++++++++++++
 tb/tb_fifo_write_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
// Two-requester burst arbiter feeding one FIFO write port; round-robin on ties, up to BURST_MAX words per grant.
// Latency: one cycle from valid to grant; ready/write strobe/write data are combinational (zero latency) within a grant.
// Backpressure: fifo_full freezes the grant, the burst count and all transfers. Optional FIFO_ARB_STARVE_CNT_EN adds starve_count.
module fifo_write_arbiter #(
    parameter int DATA_WIDTH = 12,
    parameter int BURST_MAX  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    input  logic                  fifo_full,
    output logic                  fifo_write_enable,
    output logic [DATA_WIDTH-1:0] fifo_write_data,
    output logic                  grant_id,
    output logic                  busy
`ifdef FIFO_ARB_STARVE_CNT_EN
    ,
    output logic [7:0]            starve_count
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2
    } state_e;

    // Counter value held during the final transfer of a full burst.
    localparam logic [3:0] BURST_LAST = 4'(BURST_MAX - 1);

    state_e     state_q, state_d;
    logic [3:0] burst_cnt_q, burst_cnt_d;
    // 1 means requester 1 held the most recently ended grant.
    logic       last_grant_q, last_grant_d;

    logic       xfer0;
    logic       xfer1;
    logic       xfer;
    logic       cur_valid;
    logic       oth_valid;
    logic       burst_done;
    logic       grant_end;

    // Requester-side handshake and FIFO write port, all decoded from the current state.
    always_comb begin
        req0_ready        = (state_q == ST_GRANT0) && !fifo_full;
        req1_ready        = (state_q == ST_GRANT1) && !fifo_full;
        xfer0             = req0_valid && req0_ready;
        xfer1             = req1_valid && req1_ready;
        xfer              = xfer0 || xfer1;
        fifo_write_enable = xfer;
        fifo_write_data   = '0;
        if (xfer0) begin
            fifo_write_data = req0_data;
        end else if (xfer1) begin
            fifo_write_data = req1_data;
        end
        grant_id          = (state_q == ST_GRANT1);
        busy              = (state_q != ST_IDLE);
    end

    // Grant-end detection: a full burst or an idle owner ends the grant, but never while the FIFO is full.
    always_comb begin
        cur_valid  = (state_q == ST_GRANT1) ? req1_valid : req0_valid;
        oth_valid  = (state_q == ST_GRANT1) ? req0_valid : req1_valid;
        burst_done = xfer && (burst_cnt_q == BURST_LAST);
        grant_end  = !fifo_full && (burst_done || !cur_valid);
    end

    // Next-state logic for arbitration, burst counting and the round-robin pointer.
    always_comb begin
        state_d      = state_q;
        burst_cnt_d  = burst_cnt_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ST_IDLE: begin
                burst_cnt_d = 4'd0;
                if (req0_valid && req1_valid) begin
                    // Tie: the requester that did not hold the last grant wins.
                    state_d = last_grant_q ? ST_GRANT0 : ST_GRANT1;
                end else if (req0_valid) begin
                    state_d = ST_GRANT0;
                end else if (req1_valid) begin
                    state_d = ST_GRANT1;
                end
            end
            ST_GRANT0, ST_GRANT1: begin
                if (xfer) begin
                    burst_cnt_d = burst_cnt_q + 4'd1;
                end
                if (grant_end) begin
                    last_grant_d = (state_q == ST_GRANT1);
                    burst_cnt_d  = 4'd0;
                    if (oth_valid) begin
                        state_d = (state_q == ST_GRANT1) ? ST_GRANT0 : ST_GRANT1;
                    end else if (cur_valid) begin
                        // Owner still has data after a full burst and nobody else waits: re-grant.
                        state_d = state_q;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d     = ST_IDLE;
                burst_cnt_d = 4'd0;
            end
        endcase
    end

    // Arbiter state registers; reset drops any burst in flight and favours requester 0 on the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            burst_cnt_q  <= 4'd0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            burst_cnt_q  <= burst_cnt_d;
            last_grant_q <= last_grant_d;
        end
    end

`ifdef FIFO_ARB_STARVE_CNT_EN
    logic [7:0] starve_cnt_q, starve_cnt_d;
    logic       starve_evt;

    // A cycle is a starvation cycle when the non-owner is valid during a grant; the one-cycle IDLE arbitration slot is not counted.
    always_comb begin
        starve_evt   = ((state_q == ST_GRANT0) && req1_valid) ||
                       ((state_q == ST_GRANT1) && req0_valid);
        starve_cnt_d = starve_cnt_q;
        if (starve_evt && (starve_cnt_q != 8'hFF)) begin
            starve_cnt_d = starve_cnt_q + 8'd1;
        end
    end

    // Saturating starvation counter, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= 8'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign starve_count = starve_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: reset, alternation, single-requester re-grant, FIFO-full stall, mid-burst reset.
// Inputs change 1 time unit after the rising edge; outputs are compared 1 unit later, away from the edge.
// With FIFO_ARB_STARVE_CNT_EN defined the starvation counter is also exercised.
module tb_fifo_write_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid;
    logic [11:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [11:0] req1_data;
    logic        req1_ready;
    logic        fifo_full;
    logic        fifo_write_enable;
    logic [11:0] fifo_write_data;
    logic        grant_id;
    logic        busy;
`ifdef FIFO_ARB_STARVE_CNT_EN
    logic [7:0]  starve_count;
`endif

    int checks   = 0;
    int failures = 0;

    fifo_write_arbiter #(.DATA_WIDTH(12), .BURST_MAX(4)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req0_valid        (req0_valid),
        .req0_data         (req0_data),
        .req0_ready        (req0_ready),
        .req1_valid        (req1_valid),
        .req1_data         (req1_data),
        .req1_ready        (req1_ready),
        .fifo_full         (fifo_full),
        .fifo_write_enable (fifo_write_enable),
        .fifo_write_data   (fifo_write_data),
        .grant_id          (grant_id),
        .busy              (busy)
`ifdef FIFO_ARB_STARVE_CNT_EN
        ,
        .starve_count      (starve_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; fifo_full = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1; req0_data = 12'h111; req1_data = 12'h222;
        tick(); tick(); #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (grant_id !== 1'b0) begin failures++; $display("FAIL reset_grant_id got=%b exp=0", grant_id); end
        checks++; if (fifo_write_enable !== 1'b0) begin failures++; $display("FAIL reset_wen got=%b exp=0", fifo_write_enable); end
        checks++; if (fifo_write_data !== 12'h000) begin failures++; $display("FAIL reset_wdata got=%h exp=000", fifo_write_data); end
        checks++; if ({req0_ready, req1_ready} !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b exp=00", {req0_ready, req1_ready}); end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_alternate();
        logic        exp_g;
        logic [11:0] exp_d;
        req0_valid = 1'b1; req1_valid = 1'b1; req0_data = 12'hA00; req1_data = 12'hB00; #1;
        checks++; if ({busy, fifo_write_enable} !== 2'b00) begin failures++; $display("FAIL alt_cycle0 busy/wen got=%b exp=00", {busy, fifo_write_enable}); end
        for (int c = 1; c <= 12; c++) begin
            tick();
            req0_data = 12'(12'hA00 + c); req1_data = 12'(12'hB00 + c); #1;
            exp_g = (((c - 1) / 4) % 2) == 1;
            exp_d = exp_g ? 12'(12'hB00 + c) : 12'(12'hA00 + c);
            checks++; if (grant_id !== exp_g) begin failures++; $display("FAIL alt_grant c=%0d got=%b exp=%b", c, grant_id, exp_g); end
            checks++; if (fifo_write_enable !== 1'b1 || fifo_write_data !== exp_d) begin failures++; $display("FAIL alt_write c=%0d got=%b/%h exp=1/%h", c, fifo_write_enable, fifo_write_data, exp_d); end
            checks++; if ({req0_ready, req1_ready} !== {~exp_g, exp_g}) begin failures++; $display("FAIL alt_ready c=%0d got=%b exp=%b", c, {req0_ready, req1_ready}, {~exp_g, exp_g}); end
        end
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0; #1;
        checks++; if ({busy, grant_id, fifo_write_enable} !== 3'b110) begin failures++; $display("FAIL alt_tail got=%b exp=110", {busy, grant_id, fifo_write_enable}); end
        checks++; if (fifo_write_data !== 12'h000) begin failures++; $display("FAIL alt_tail_data got=%h exp=000", fifo_write_data); end
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL alt_idle got=%b exp=0", busy); end
    endtask

    task automatic test_single_req1();
        logic [11:0] exp_d;
        req1_valid = 1'b1; req1_data = 12'h300; #1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            req1_data = 12'(12'h300 + c); #1;
            exp_d = 12'(12'h300 + c);
            checks++; if ({busy, grant_id, fifo_write_enable} !== 3'b111) begin failures++; $display("FAIL single_state c=%0d got=%b exp=111", c, {busy, grant_id, fifo_write_enable}); end
            checks++; if (fifo_write_data !== exp_d) begin failures++; $display("FAIL single_data c=%0d got=%h exp=%h", c, fifo_write_data, exp_d); end
            checks++; if ({req0_ready, req1_ready} !== 2'b01) begin failures++; $display("FAIL single_ready c=%0d got=%b exp=01", c, {req0_ready, req1_ready}); end
        end
        tick();
        req1_valid = 1'b0; #1;
        checks++; if ({busy, grant_id, fifo_write_enable} !== 3'b110) begin failures++; $display("FAIL single_drop got=%b exp=110", {busy, grant_id, fifo_write_enable}); end
        tick();
        checks++; if ({busy, grant_id} !== 2'b00) begin failures++; $display("FAIL single_idle got=%b exp=00", {busy, grant_id}); end
    endtask

    task automatic test_fifo_full();
        req0_valid = 1'b1; req0_data = 12'hC01; #1;
        tick();
        checks++; if (fifo_write_enable !== 1'b1 || fifo_write_data !== 12'hC01) begin failures++; $display("FAIL full_w1 got=%b/%h exp=1/c01", fifo_write_enable, fifo_write_data); end
        tick();
        req0_data = 12'hC02; #1;
        checks++; if (fifo_write_enable !== 1'b1 || fifo_write_data !== 12'hC02) begin failures++; $display("FAIL full_w2 got=%b/%h exp=1/c02", fifo_write_enable, fifo_write_data); end
        for (int k = 0; k < 3; k++) begin
            tick();
            fifo_full = 1'b1; req0_data = 12'hC03;
            req0_valid = (k != 1); #1;
            checks++; if ({req0_ready, fifo_write_enable} !== 2'b00) begin failures++; $display("FAIL full_stall k=%0d ready/wen got=%b exp=00", k, {req0_ready, fifo_write_enable}); end
            checks++; if ({busy, grant_id} !== 2'b10 || fifo_write_data !== 12'h000) begin failures++; $display("FAIL full_hold k=%0d got=%b/%h exp=10/000", k, {busy, grant_id}, fifo_write_data); end
        end
        tick();
        fifo_full = 1'b0; req0_valid = 1'b1; #1;
        checks++; if (fifo_write_enable !== 1'b1 || fifo_write_data !== 12'hC03 || req0_ready !== 1'b1) begin failures++; $display("FAIL full_w3 got=%b/%h exp=1/c03", fifo_write_enable, fifo_write_data); end
        tick();
        req0_data = 12'hC04; req1_valid = 1'b1; req1_data = 12'hD01; #1;
        checks++; if (fifo_write_enable !== 1'b1 || fifo_write_data !== 12'hC04) begin failures++; $display("FAIL full_w4 got=%b/%h exp=1/c04", fifo_write_enable, fifo_write_data); end
        tick();
        checks++; if ({busy, grant_id} !== 2'b11 || fifo_write_data !== 12'hD01) begin failures++; $display("FAIL full_burst_end got=%b/%h exp=11/d01", {busy, grant_id}, fifo_write_data); end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL full_idle got=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid();
        req0_valid = 1'b1; req0_data = 12'hE01; #1;
        tick();
        checks++; if ({grant_id, fifo_write_enable} !== 2'b01 || fifo_write_data !== 12'hE01) begin failures++; $display("FAIL rmid_pre got=%b/%h exp=01/e01", {grant_id, fifo_write_enable}, fifo_write_data); end
        tick();
        req0_valid = 1'b0; #1;
        tick();
        req0_valid = 1'b1; req1_valid = 1'b1; req0_data = 12'hE02; req1_data = 12'hF01; #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_idle got=%b exp=0", busy); end
        tick();
        checks++; if (grant_id !== 1'b1 || fifo_write_data !== 12'hF01) begin failures++; $display("FAIL rmid_rr_tie got=%b/%h exp=1/f01", grant_id, fifo_write_data); end
        tick();
        req1_data = 12'hF02; #1;
        checks++; if (fifo_write_enable !== 1'b1 || fifo_write_data !== 12'hF02) begin failures++; $display("FAIL rmid_w2 got=%b/%h exp=1/f02", fifo_write_enable, fifo_write_data); end
        rst_n = 1'b0; #1;
        checks++; if ({busy, fifo_write_enable, req1_ready} !== 3'b000 || fifo_write_data !== 12'h000) begin failures++; $display("FAIL rmid_async got=%b/%h exp=000/000", {busy, fifo_write_enable, req1_ready}, fifo_write_data); end
        tick();
        checks++; if ({busy, fifo_write_enable} !== 2'b00) begin failures++; $display("FAIL rmid_held got=%b exp=00", {busy, fifo_write_enable}); end
        rst_n = 1'b1;
        tick();
        checks++; if ({busy, grant_id, fifo_write_enable} !== 3'b101 || fifo_write_data !== 12'hE02) begin failures++; $display("FAIL rmid_restart got=%b/%h exp=101/e02", {busy, grant_id, fifo_write_enable}, fifo_write_data); end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_drain got=%b exp=0", busy); end
    endtask

`ifdef FIFO_ARB_STARVE_CNT_EN
    task automatic test_starve();
        rst_n = 1'b0; #1; rst_n = 1'b1; #1;
        checks++; if (starve_count !== 8'd0) begin failures++; $display("FAIL starve_reset got=%0d exp=0", starve_count); end
        req0_valid = 1'b1; req0_data = 12'h501;
        tick();
        req1_valid = 1'b1; req1_data = 12'h601;
        tick();
        fifo_full = 1'b1; #1;
        checks++; if (fifo_write_enable !== 1'b0) begin failures++; $display("FAIL starve_stall got=%b exp=0", fifo_write_enable); end
        tick(); fifo_full = 1'b0;
        tick();
        tick();
        tick();
        req0_valid = 1'b0; #1;
        checks++; if (grant_id !== 1'b1) begin failures++; $display("FAIL starve_grant got=%b exp=1", grant_id); end
        checks++; if (starve_count !== 8'd5) begin failures++; $display("FAIL starve_count got=%0d exp=5", starve_count); end
        req0_valid = 1'b1; fifo_full = 1'b1;
        repeat (300) tick();
        checks++; if (starve_count !== 8'hFF) begin failures++; $display("FAIL starve_sat got=%h exp=ff", starve_count); end
        req0_valid = 1'b0; req1_valid = 1'b0; fifo_full = 1'b0;
        rst_n = 1'b0; #1; rst_n = 1'b1;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_alternate();
        test_single_req1();
        test_fifo_full();
        test_reset_mid();
`ifdef FIFO_ARB_STARVE_CNT_EN
        test_starve();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
